// File: rtl/decode_stage.sv
// decode_stage: single-entry pipelined RV32I (+ optional M) decoder.
// Fetch side and execute side both use valid/ready. The output register
// holds one decoded instruction and is cleared by flush or reset.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alu_ctl,
    output logic            out_alu_src,
    output logic            out_a_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            out_link,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic [1:0]      out_mem_size,
    output logic            out_mem_unsigned,
    output logic            out_branch_c,
    output logic            out_branch_uc,
    output logic            out_branch_relative,
    output logic            out_illegal
);

    localparam logic [4:0] ALU_AND  = 5'd0;
    localparam logic [4:0] ALU_OR   = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_XOR  = 5'd3;
    localparam logic [4:0] ALU_SLL  = 5'd4;
    localparam logic [4:0] ALU_SRL  = 5'd5;
    localparam logic [4:0] ALU_SRA  = 5'd6;
    localparam logic [4:0] ALU_LT   = 5'd7;
    localparam logic [4:0] ALU_GE   = 5'd8;
    localparam logic [4:0] ALU_SUB  = 5'd9;
    localparam logic [4:0] ALU_CHB  = 5'd10;
    localparam logic [4:0] ALU_LTU  = 5'd11;
    localparam logic [4:0] ALU_GEU  = 5'd12;
    localparam logic [4:0] ALU_EQ   = 5'd13;
    localparam logic [4:0] ALU_NE   = 5'd14;
    localparam logic [4:0] ALU_ZERO = 5'd31;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_ctl;
        logic            alu_src;
        logic            a_pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            link;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      mem_size;
        logic            mem_unsigned;
        logic            branch_c;
        logic            branch_uc;
        logic            branch_relative;
        logic            illegal;
    } dec_t;

    // Shared R-type / OP-IMM mapping; alt selects sub and sra.
    function automatic logic [4:0] base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_LT;
            3'd3:    return ALU_LTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Widen a 32-bit signed immediate to the datapath width.
    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm32;
    logic               legal;
    logic               writes;
    logic               accept;
    dec_t               dec_p0;
    dec_t               dec_p1;
    logic               vld_p1;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage p0: combinational decode of the presented instruction.
    always_comb begin
        dec_p0         = '0;
        dec_p0.pc      = in_pc;
        dec_p0.rs1     = in_instr[19:15];
        dec_p0.rs2     = in_instr[24:20];
        dec_p0.rd      = in_instr[11:7];
        dec_p0.alu_ctl = ALU_ZERO;
        imm32          = '0;
        legal          = 1'b1;
        writes         = 1'b0;
        case (opcode)
            OP_R: begin
                writes = 1'b1;
                if (funct7 == 7'b0000000)
                    dec_p0.alu_ctl = base_op(funct3, 1'b0);
                else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))
                    dec_p0.alu_ctl = base_op(funct3, 1'b1);
                else if (funct7 == 7'b0000001 && M_EXT != 0)
                    dec_p0.alu_ctl = {2'b10, funct3};
                else
                    legal = 1'b0;
            end
            OP_IMM: begin
                writes         = 1'b1;
                dec_p0.alu_src = 1'b1;
                imm32          = {{20{in_instr[31]}}, in_instr[31:20]};
                if (funct3 == 3'd1) begin
                    dec_p0.alu_ctl = ALU_SLL;
                    legal          = (funct7 == 7'b0000000);
                end else if (funct3 == 3'd5) begin
                    dec_p0.alu_ctl = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
                    legal          = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    dec_p0.alu_ctl = base_op(funct3, 1'b0);
                end
            end
            OP_LOAD: begin
                writes              = 1'b1;
                dec_p0.alu_ctl      = ALU_ADD;
                dec_p0.alu_src      = 1'b1;
                dec_p0.mem_read     = 1'b1;
                dec_p0.mem_size     = funct3[1:0];
                dec_p0.mem_unsigned = funct3[2];
                imm32               = {{20{in_instr[31]}}, in_instr[31:20]};
                legal               = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
            end
            OP_STORE: begin
                dec_p0.alu_ctl   = ALU_ADD;
                dec_p0.alu_src   = 1'b1;
                dec_p0.mem_write = 1'b1;
                dec_p0.mem_size  = funct3[1:0];
                imm32            = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                legal            = (funct3 <= 3'd2);
            end
            OP_BR: begin
                dec_p0.branch_c        = 1'b1;
                dec_p0.branch_relative = 1'b1;
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
                case (funct3)
                    3'd0:    dec_p0.alu_ctl = ALU_EQ;
                    3'd1:    dec_p0.alu_ctl = ALU_NE;
                    3'd4:    dec_p0.alu_ctl = ALU_LT;
                    3'd5:    dec_p0.alu_ctl = ALU_GE;
                    3'd6:    dec_p0.alu_ctl = ALU_LTU;
                    3'd7:    dec_p0.alu_ctl = ALU_GEU;
                    default: legal = 1'b0;
                endcase
            end
            OP_JAL: begin
                writes                 = 1'b1;
                dec_p0.alu_ctl         = ALU_CHB;
                dec_p0.branch_uc       = 1'b1;
                dec_p0.branch_relative = 1'b1;
                dec_p0.link            = 1'b1;
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                writes           = 1'b1;
                dec_p0.alu_ctl   = ALU_ADD;
                dec_p0.alu_src   = 1'b1;
                dec_p0.branch_uc = 1'b1;
                dec_p0.link      = 1'b1;
                imm32            = {{20{in_instr[31]}}, in_instr[31:20]};
                legal            = (funct3 == 3'd0);
            end
            OP_LUI: begin
                writes         = 1'b1;
                dec_p0.alu_ctl = ALU_CHB;
                dec_p0.alu_src = 1'b1;
                imm32          = {in_instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                writes         = 1'b1;
                dec_p0.alu_ctl = ALU_ADD;
                dec_p0.alu_src = 1'b1;
                dec_p0.a_pc    = 1'b1;
                imm32          = {in_instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase

        dec_p0.imm       = sext32(imm32);
        dec_p0.reg_write = legal && writes && (in_instr[11:7] != 5'd0);

        // An illegal encoding passes through carrying only its register
        // fields and the illegal flag, so nothing downstream acts on it.
        if (!legal) begin
            dec_p0.imm             = '0;
            dec_p0.alu_ctl         = ALU_ZERO;
            dec_p0.alu_src         = 1'b0;
            dec_p0.a_pc            = 1'b0;
            dec_p0.link            = 1'b0;
            dec_p0.mem_read        = 1'b0;
            dec_p0.mem_write       = 1'b0;
            dec_p0.mem_size        = 2'd0;
            dec_p0.mem_unsigned    = 1'b0;
            dec_p0.branch_c        = 1'b0;
            dec_p0.branch_uc       = 1'b0;
            dec_p0.branch_relative = 1'b0;
            dec_p0.illegal         = 1'b1;
        end
    end

    // Stage p1: output register; payload loads only on a surviving accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1         <= 1'b0;
            dec_p1         <= '0;
            dec_p1.alu_ctl <= ALU_ZERO;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (accept)
                vld_p1 <= 1'b1;
            else if (out_ready)
                vld_p1 <= 1'b0;
            if (accept && !flush)
                dec_p1 <= dec_p0;
        end
    end

    assign out_valid           = vld_p1;
    assign out_pc              = dec_p1.pc;
    assign out_imm             = dec_p1.imm;
    assign out_alu_ctl         = dec_p1.alu_ctl;
    assign out_alu_src         = dec_p1.alu_src;
    assign out_a_pc            = dec_p1.a_pc;
    assign out_rs1             = dec_p1.rs1;
    assign out_rs2             = dec_p1.rs2;
    assign out_rd              = dec_p1.rd;
    assign out_reg_write       = dec_p1.reg_write;
    assign out_link            = dec_p1.link;
    assign out_mem_read        = dec_p1.mem_read;
    assign out_mem_write       = dec_p1.mem_write;
    assign out_mem_size        = dec_p1.mem_size;
    assign out_mem_unsigned    = dec_p1.mem_unsigned;
    assign out_branch_c        = dec_p1.branch_c;
    assign out_branch_uc       = dec_p1.branch_uc;
    assign out_branch_relative = dec_p1.branch_relative;
    assign out_illegal         = dec_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus hand-written handshake,
// flush and reset sequences. Instance a is XLEN=32/M_EXT=0, instance b
// is XLEN=64/M_EXT=1; both see the same instruction stream.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [31:0] pc_a;
    logic [63:0] pc_b;

    logic        a_in_ready, a_valid, a_src, a_apc, a_rw, a_link, a_mr, a_mw;
    logic        a_mu, a_bc, a_buc, a_brel, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_alu, a_rs1, a_rs2, a_rd;
    logic [1:0]  a_msz;

    logic        b_in_ready, b_valid, b_src, b_apc, b_rw, b_link, b_mr, b_mw;
    logic        b_mu, b_bc, b_buc, b_brel, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_alu, b_rs1, b_rs2, b_rd;
    logic [1:0]  b_msz;

    decode_stage #(.XLEN(32), .M_EXT(0)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(pc_a), .out_valid(a_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_imm(a_imm), .out_alu_ctl(a_alu), .out_alu_src(a_src),
        .out_a_pc(a_apc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
        .out_reg_write(a_rw), .out_link(a_link), .out_mem_read(a_mr), .out_mem_write(a_mw),
        .out_mem_size(a_msz), .out_mem_unsigned(a_mu), .out_branch_c(a_bc),
        .out_branch_uc(a_buc), .out_branch_relative(a_brel), .out_illegal(a_ill)
    );

    decode_stage #(.XLEN(64), .M_EXT(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(pc_b), .out_valid(b_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_imm(b_imm), .out_alu_ctl(b_alu), .out_alu_src(b_src),
        .out_a_pc(b_apc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
        .out_reg_write(b_rw), .out_link(b_link), .out_mem_read(b_mr), .out_mem_write(b_mw),
        .out_mem_size(b_msz), .out_mem_unsigned(b_mu), .out_branch_c(b_bc),
        .out_branch_uc(b_buc), .out_branch_relative(b_brel), .out_illegal(b_ill)
    );

    typedef struct {
        int unsigned instr, alu, imm, src, apc, rd, rw, link, mr, mw;
        int unsigned msz, mu, bc, buc, brel, ill, balu, bill;
    } vec_t;

    vec_t tbl[18];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              instr         alu imm          src apc rd rw lk mr mw sz mu bc bu br il balu bill
        tbl[0]  = '{32'hFFF00093,  2, 32'hFFFFFFFF, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0}; // addi x1,x0,-1
        tbl[1]  = '{32'h402081B3,  9, 32'h00000000, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  9, 0}; // sub
        tbl[2]  = '{32'hFFDFF0EF, 10, 32'hFFFFFFFC, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 10, 0}; // jal x1,-4
        tbl[3]  = '{32'h00008067,  2, 32'h00000000, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0,  2, 0}; // jalr x0,0(x1)
        tbl[4]  = '{32'h0000A103,  2, 32'h00000000, 1, 0, 2, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0,  2, 0}; // lw x2,0(x1)
        tbl[5]  = '{32'h0020A223,  2, 32'h00000004, 1, 0, 4, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0,  2, 0}; // sw x2,4(x1)
        tbl[6]  = '{32'h00208463, 13, 32'h00000008, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 13, 0}; // beq +8
        tbl[7]  = '{32'hFE209CE3, 14, 32'hFFFFFFF8, 0, 0,25, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 14, 0}; // bne -8
        tbl[8]  = '{32'h800002B7, 10, 32'h80000000, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 0}; // lui x5,0x80000
        tbl[9]  = '{32'h00001317,  2, 32'h00001000, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0}; // auipc x6,1
        tbl[10] = '{32'hFFF0C383,  2, 32'hFFFFFFFF, 1, 0, 7, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0,  2, 0}; // lbu x7,-1(x1)
        tbl[11] = '{32'h4030D413,  6, 32'h00000403, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6, 0}; // srai x8,x1,3
        tbl[12] = '{32'h40309413, 31, 32'h00000000, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 1}; // slli bad funct7
        tbl[13] = '{32'h02208133, 31, 32'h00000000, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16, 0}; // mul
        tbl[14] = '{32'h0020A463, 31, 32'h00000000, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 1}; // branch funct3=2
        tbl[15] = '{32'h003130B3, 11, 32'h00000000, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11, 0}; // sltu
        tbl[16] = '{32'h00000000, 31, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 1}; // opcode 0
        tbl[17] = '{32'h00208033,  2, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0}; // add x0

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; pc_a = 32'h0; pc_b = 64'h0;
        repeat (2) step();
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_alu", 64'(a_alu), 64'd31);
        chk("rst_imm", 64'(a_imm), 64'd0);
        chk("rst_rw", 64'(a_rw), 64'd0);
        chk("rst_pc", 64'(a_pc), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_b_alu", 64'(b_alu), 64'd31);
        rst = 1'b0;
        step();

        // Back-to-back stream with execute always ready.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 18; k++) begin
            logic [31:0] e_imm;
            in_instr = tbl[k].instr;
            pc_a     = 32'h1000 + 32'(4 * k);
            pc_b     = 64'hFFFF_0000_0000_1000 + 64'(4 * k);
            step();
            e_imm = tbl[k].imm;
            chk($sformatf("v%0d_valid", k), 64'(a_valid), 64'd1);
            chk($sformatf("v%0d_in_ready", k), 64'(a_in_ready), 64'd1);
            chk($sformatf("v%0d_pc", k), 64'(a_pc), 64'h1000 + 64'(4 * k));
            chk($sformatf("v%0d_alu", k), 64'(a_alu), 64'(tbl[k].alu));
            chk($sformatf("v%0d_imm", k), 64'(a_imm), 64'(e_imm));
            chk($sformatf("v%0d_src", k), 64'(a_src), 64'(tbl[k].src));
            chk($sformatf("v%0d_apc", k), 64'(a_apc), 64'(tbl[k].apc));
            chk($sformatf("v%0d_rd", k), 64'(a_rd), 64'(tbl[k].rd));
            chk($sformatf("v%0d_rw", k), 64'(a_rw), 64'(tbl[k].rw));
            chk($sformatf("v%0d_link", k), 64'(a_link), 64'(tbl[k].link));
            chk($sformatf("v%0d_mr", k), 64'(a_mr), 64'(tbl[k].mr));
            chk($sformatf("v%0d_mw", k), 64'(a_mw), 64'(tbl[k].mw));
            chk($sformatf("v%0d_msz", k), 64'(a_msz), 64'(tbl[k].msz));
            chk($sformatf("v%0d_mu", k), 64'(a_mu), 64'(tbl[k].mu));
            chk($sformatf("v%0d_bc", k), 64'(a_bc), 64'(tbl[k].bc));
            chk($sformatf("v%0d_buc", k), 64'(a_buc), 64'(tbl[k].buc));
            chk($sformatf("v%0d_brel", k), 64'(a_brel), 64'(tbl[k].brel));
            chk($sformatf("v%0d_ill", k), 64'(a_ill), 64'(tbl[k].ill));
            chk($sformatf("v%0d_b_alu", k), 64'(b_alu), 64'(tbl[k].balu));
            chk($sformatf("v%0d_b_ill", k), 64'(b_ill), 64'(tbl[k].bill));
            chk($sformatf("v%0d_b_imm", k), b_imm, {{32{e_imm[31]}}, e_imm});
            chk($sformatf("v%0d_b_pc", k), b_pc, 64'hFFFF_0000_0000_1000 + 64'(4 * k));
            if (tbl[k].instr == 32'h02208133)
                chk("b_mul_rw", 64'(b_rw), 64'd1);
        end

        // Backpressure: lw held for three cycles, then addi follows.
        in_instr = 32'h0000A103;
        step();
        chk("bp_lw_valid", 64'(a_valid), 64'd1);
        out_ready = 1'b0;
        in_instr  = 32'hFFF00093;
        #1;
        chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("bp%0d_valid", c), 64'(a_valid), 64'd1);
            chk($sformatf("bp%0d_mr", c), 64'(a_mr), 64'd1);
            chk($sformatf("bp%0d_msz", c), 64'(a_msz), 64'd2);
            chk($sformatf("bp%0d_rd", c), 64'(a_rd), 64'd2);
            chk($sformatf("bp%0d_in_ready", c), 64'(a_in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(a_in_ready), 64'd1);
        step();
        chk("bp_next_valid", 64'(a_valid), 64'd1);
        chk("bp_next_alu", 64'(a_alu), 64'd2);
        chk("bp_next_rd", 64'(a_rd), 64'd1);
        chk("bp_next_mr", 64'(a_mr), 64'd0);
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", 64'(a_valid), 64'd0);

        // Flush in the same cycle as a beq accept.
        in_instr = 32'h00208463;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("fl_in_ready", 64'(a_in_ready), 64'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid0", 64'(a_valid), 64'd0);
        chk("fl_bc0", 64'(a_bc), 64'd0);
        step();
        chk("fl_valid1", 64'(a_valid), 64'd0);
        chk("fl_bc1", 64'(a_bc), 64'd0);

        // Flush of an instruction held under backpressure.
        in_instr = 32'hFFF00093;
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("flh_valid", 64'(a_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flh_cleared", 64'(a_valid), 64'd0);
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a stall.
        in_instr = 32'h402081B3;
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        chk("ar_stall_valid", 64'(a_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(a_valid), 64'd0);
        chk("ar_alu", 64'(a_alu), 64'd31);
        chk("ar_rd", 64'(a_rd), 64'd0);
        chk("ar_rw", 64'(a_rw), 64'd0);
        #1 rst = 1'b0;
        step();
        chk("ar_post_valid0", 64'(a_valid), 64'd0);
        out_ready = 1'b1;
        step();
        chk("ar_post_valid1", 64'(a_valid), 64'd0);
        chk("ar_post_rw", 64'(a_rw), 64'd0);
        in_instr = 32'hFFF00093;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ar_new_valid", 64'(a_valid), 64'd1);
        chk("ar_new_alu", 64'(a_alu), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I instruction decoder (optional M extension) with a valid/ready handshake on both sides. It replaces the state-gated multicycle decoder. It sits between fetch and execute, holds exactly one decoded instruction in its output register, and can be flushed by branch resolution. Immediates are sign-extended to a parametrised datapath width.

## Interface
- XLEN, 32: datapath width for `in_pc`, `out_pc` and `out_imm`; legal values are 32 and 64.
- M_EXT, 0: 1 decodes MUL/DIV (funct7=0000001); 0 flags them illegal.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard the held instruction and any instruction accepted in this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  the stage can accept an instruction this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of `in_instr`.
- out_valid  out  1  decoded payload is valid.
- out_ready  in  1  execute consumes the payload.
- out_pc  out  XLEN  registered copy of `in_pc`.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_ctl  out  5  ALU operation code.
- out_alu_src  out  1  1: operand B = imm; 0: operand B = rs2.
- out_a_pc  out  1  1: operand A = PC (auipc); 0: operand A = rs1.
- out_rs1, out_rs2, out_rd  out  5  register indices, taken from instr[19:15], [24:20], [11:7].
- out_reg_write  out  1  write rd.
- out_link  out  1  write PC+4 to rd (jal, jalr).
- out_mem_read, out_mem_write  out  1  load, store.
- out_mem_size  out  2  0 byte, 1 half, 2 word (funct3[1:0]).
- out_mem_unsigned  out  1  lbu, lhu.
- out_branch_c, out_branch_uc, out_branch_relative  out  1  conditional branch; jal/jalr; PC-relative target (0 only for jalr).
- out_illegal  out  1  unrecognised encoding.

## Operation
- ALU codes:
  - 0 and, 1 or, 2 add, 3 xor, 4 sll, 5 srl, 6 sra, 7 lt, 8 ge, 9 sub, 10 chooseb, 11 ltu, 12 geu, 13 eq, 14 ne.
  - 16–23: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
  - 31: zero.
- R-type (0110011): funct3/funct7 select the op.
  - add and sub use funct7 bit 5; srl and sra use funct7 bit 5.
  - slt maps to 7, sltu maps to 11.
  - Any other funct7 value is illegal.
- OP-IMM (0010011): same op mapping as R-type.
  - slli/srli/srai require funct7 ∈ {0000000, 0100000(sr only)}.
- Load (0000011): funct3 ∈ {0,1,2,4,5}, ALU op add.
- Store (0100011): funct3 ∈ {0,1,2}, ALU op add, no register write.
- Branch (1100011): beq→13, bne→14, blt→7, bge→8, bltu→11, bgeu→12. funct3 2 and 3 are illegal. No register write.
- jal (1101111): ALU op chooseb, `branch_uc=1`, `link=1`.
- jalr (1100111, funct3=0): ALU op add, `alu_src=1`, `branch_uc=1`, `branch_relative=0`, `link=1`.
- lui (0110111): ALU op chooseb, `alu_src=1`.
- auipc (0010111): ALU op add, `a_pc=1`, `alu_src=1`.
- Immediates (I/S/B/U/J) are sign-extended from instr[31] to XLEN bits.
  - J immediate is {instr[31], [19:12], [20], [30:21], 0}, sign-extended.
  - U immediate is {instr[31:12], 12'b0}, sign-extended.
  - All other types produce imm=0.
- `out_reg_write=1` only for a legal instruction with a writing type and rd≠0.
- Illegal instruction: `out_illegal=1`, alu_ctl=31, and all of reg_write/link/mem_*/branch_* forced to 0. The instruction still passes through with valid=1.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears with `out_valid=1` after edge N.
- `in_ready = !out_valid || out_ready`. This path is combinational and has no other dependency.
- Accept occurs when `in_valid && in_ready`. The output register loads the new payload at that edge.
- `out_valid && !out_ready`: every out_* signal holds stable and `in_ready=0`.
- Output consumed with no new accept: `out_valid` goes to 0 and the payload is don't-care but stays held.
- Back-to-back transfer: with `out_ready=1` and `in_valid=1` every cycle, throughput is one instruction per cycle with no bubble.
- flush:
  - At the next edge `out_valid=0`. Any accept in the same cycle is dropped.
  - `in_ready` is still computed normally during flush, so fetch sees the drop as a transfer.
- rst (asynchronous):
  - `out_valid=0`, `out_alu_ctl=31`, and all other outputs 0.
  - A reset asserted mid-stall discards the held instruction.

## Test plan
- Directed ops, back-to-back with `out_ready=1`:
  - addi x1,x0,-1 (0xFFF00093) → alu_ctl=2, alu_src=1, imm=0xFFFFFFFF, rd=1, reg_write=1.
  - sub x3,x1,x2 (0x402081B3) → alu_ctl=9, alu_src=0.
- Immediates:
  - jal x1,-4 (0xFFDFF0EF) → imm=0xFFFFFFFC, branch_uc=1, link=1, branch_relative=1.
  - jalr x0,0(x1) (0x00008067) → branch_relative=0, reg_write=0 (rd=0).
- Backpressure: hold `out_ready=0` for 3 cycles after lw (0x0000A103).
  - `in_ready=0`, payload stable: mem_read=1, mem_size=2.
  - Release → the next instruction appears on the following edge.
- Flush: accept beq (0x00208463) while asserting flush → `out_valid=0` the next cycle, and no branch_c pulse is observed.
- M_EXT: mul (0x02208133) → alu_ctl=16 with M_EXT=1; with M_EXT=0 → illegal=1, reg_write=0. With XLEN=64, lui 0x80000 gives imm=0xFFFFFFFF80000000.
- Reset: assert rst asynchronously mid-stall → out_valid drops immediately and alu_ctl=31. No output pulses after deassert until a new accept.
